// File: rtl/instr_encoder.sv
// instr_encoder: packs instruction fields into 32-bit words and writes them to memory through a 4-deep FIFO; ENC_CHECK_EN drops illegal encodings.
// Latency: a write starts 2 cycles after a push at the earliest. Backpressure: InReady is low while the FIFO is full, and a write is held until MemReady.
module instr_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        InValid,
  output logic        InReady,
  input  logic [3:0]  Cond,
  input  logic [1:0]  Op,
  input  logic [5:0]  Funct,
  input  logic [3:0]  Rn,
  input  logic [3:0]  Rd,
  input  logic [23:0] Imm,
  input  logic        Start,
  input  logic [31:0] BaseAdr,
  output logic [31:0] MemAdr,
  output logic [31:0] MemWD,
  output logic        MemWE,
  input  logic        MemReady,
  output logic        Busy,
  output logic [7:0]  WordCount,
  output logic        Err
);

  typedef enum logic [1:0] {IDLE, ARMED, WRITE} state_t;

  state_t      state, state_nxt;
  logic [31:0] fifo_mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count;
  logic [31:0] enc_word;
  logic        accept, drop, push, pop;

  always_comb begin
    enc_word = {Cond, Op, Funct, Rn, Rd, Imm[11:0]};
    if (Op == 2'b10)
      enc_word = {Cond, 2'b10, Funct[5:4], Imm};
  end

  assign InReady = (count < 3'd4);
  assign accept  = InValid & InReady;

`ifdef ENC_CHECK_EN
  logic illegal;
  logic err_q;

  // Data-processing is limited to AND, SUB, ADD and ORR
  always_comb begin
    illegal = 1'b0;
    if (Op == 2'b11)
      illegal = 1'b1;
    else if (Op == 2'b00) begin
      case (Funct[4:1])
        4'b0100, 4'b0010, 4'b0000, 4'b1100: illegal = 1'b0;
        default:                            illegal = 1'b1;
      endcase
    end
  end

  assign drop = accept & illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_q <= 1'b0;
    else
      err_q <= drop;
  end

  assign Err = err_q;
`else
  assign drop = 1'b0;
  assign Err  = 1'b0;
`endif

  assign push = accept & ~drop;
  assign pop  = (state == WRITE) & MemReady;

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= enc_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 2'd1;
      if (pop)
        rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Start in ARMED wins over launching a write in the same cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = ARMED;
      ARMED:   if (!Start && count != 3'd0) state_nxt = WRITE;
      WRITE:   if (MemReady) state_nxt = ARMED;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      MemAdr    <= 32'd0;
      MemWD     <= 32'd0;
      WordCount <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (Start)
            MemAdr <= BaseAdr & ~32'd3;
        end
        ARMED: begin
          if (Start) begin
            MemAdr    <= BaseAdr & ~32'd3;
            WordCount <= 8'd0;
          end else if (count != 3'd0) begin
            MemWD <= fifo_mem[rd_ptr];
          end
        end
        WRITE: begin
          if (MemReady) begin
            MemAdr    <= MemAdr + 32'd4;
            WordCount <= WordCount + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign MemWE = (state == WRITE);
  assign Busy  = (state == WRITE) | (count != 3'd0);

endmodule

// File: tb/tb_instr_encoder.sv
// Directed sequence plus random field sets against a queue-based model of the encoder's memory writes.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        InValid;
  logic        InReady;
  logic [3:0]  Cond;
  logic [1:0]  Op;
  logic [5:0]  Funct;
  logic [3:0]  Rn;
  logic [3:0]  Rd;
  logic [23:0] Imm;
  logic        Start;
  logic [31:0] BaseAdr;
  logic [31:0] MemAdr;
  logic [31:0] MemWD;
  logic        MemWE;
  logic        MemReady;
  logic        Busy;
  logic [7:0]  WordCount;
  logic        Err;

  int errors = 0;
  int checks = 0;
  int we_cycles = 0;
  bit rand_rdy = 1'b0;
  logic [31:0] model_addr = 32'd0;
  logic [31:0] obs_adr[$];
  logic [31:0] obs_wd[$];
  logic [31:0] exp_adr[$];
  logic [31:0] exp_wd[$];

  instr_encoder dut (
    .clk(clk), .reset(reset), .InValid(InValid), .InReady(InReady),
    .Cond(Cond), .Op(Op), .Funct(Funct), .Rn(Rn), .Rd(Rd), .Imm(Imm),
    .Start(Start), .BaseAdr(BaseAdr), .MemAdr(MemAdr), .MemWD(MemWD),
    .MemWE(MemWE), .MemReady(MemReady), .Busy(Busy),
    .WordCount(WordCount), .Err(Err)
  );

  always #5 clk = ~clk;

  // A write completes on the rising edge after a negedge that sees MemWE and MemReady
  always @(negedge clk) begin
    if (MemWE === 1'b1) begin
      we_cycles++;
      if (MemReady === 1'b1) begin
        obs_adr.push_back(MemAdr);
        obs_wd.push_back(MemWD);
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      MemReady = 1'($urandom_range(0, 1));
    end
  end

  function automatic logic [31:0] model_enc(input logic [3:0] c, input logic [1:0] o,
                                            input logic [5:0] f, input logic [3:0] rn,
                                            input logic [3:0] rd, input logic [23:0] im);
    logic [31:0] w;
    if (o == 2'd2)
      w = 32'(c) * 32'h1000_0000 + 32'd2 * 32'h0400_0000 + (32'(f) / 32'd16) * 32'h0100_0000 + 32'(im);
    else
      w = 32'(c) * 32'h1000_0000 + 32'(o) * 32'h0400_0000 + 32'(f) * 32'h0010_0000
        + 32'(rn) * 32'h0001_0000 + 32'(rd) * 32'h0000_1000 + (32'(im) % 32'd4096);
    return w;
  endfunction

  function automatic bit model_legal(input logic [1:0] o, input logic [5:0] f);
`ifdef ENC_CHECK_EN
    logic [3:0] cmd;
    cmd = f[4:1];
    if (o == 2'd3) return 1'b0;
    if (o == 2'd0) return (cmd inside {4'd4, 4'd2, 4'd0, 4'd12});
`endif
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                            input logic [3:0] rn, input logic [3:0] rd, input logic [23:0] im);
    Cond = c; Op = o; Funct = f; Rn = rn; Rd = rd; Imm = im;
  endtask

  task automatic model_push();
    if (model_legal(Op, Funct)) begin
      exp_wd.push_back(model_enc(Cond, Op, Funct, Rn, Rd, Imm));
      exp_adr.push_back(model_addr);
      model_addr = model_addr + 32'd4;
    end
  endtask

  task automatic wait_acc();
    bit done = 1'b0;
    int n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      if (InReady === 1'b1) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
      n++;
    end
    chk("accept_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic push(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                      input logic [3:0] rn, input logic [3:0] rd, input logic [23:0] im);
    set_fields(c, o, f, rn, rd, im);
    InValid = 1'b1;
    wait_acc();
    InValid = 1'b0;
    model_push();
  endtask

  task automatic push_rand(input bit legal_only);
    logic [1:0] o;
    logic [5:0] f;
    logic [3:0] cmds [4];
    cmds = '{4'd4, 4'd2, 4'd0, 4'd12};
    o = legal_only ? 2'($urandom_range(0, 2)) : 2'($urandom_range(0, 3));
    f = 6'($urandom);
    if (legal_only && o == 2'd0) f[4:1] = cmds[$urandom_range(0, 3)];
    if (o == 2'd2) f[5] = 1'b1;
    push(4'($urandom), o, f, 4'($urandom), 4'($urandom), 24'($urandom));
  endtask

  task automatic start(input logic [31:0] b);
    Start = 1'b1;
    BaseAdr = b;
    tick(1);
    Start = 1'b0;
    model_addr = b & ~32'd3;
  endtask

  task automatic drain();
    int n = 0;
    while (Busy !== 1'b0 && n < 500) begin
      tick(1);
      n++;
    end
    chk("drain_busy", {31'd0, Busy}, 32'd0);
    tick(1);
  endtask

  task automatic compare(input string tag);
    int n;
    n = exp_wd.size();
    chk({tag, "_nwrites"}, 32'(obs_wd.size()), 32'(n));
    for (int i = 0; i < n && i < obs_wd.size(); i++) begin
      chk($sformatf("%s_adr%0d", tag, i), obs_adr[i], exp_adr[i]);
      chk($sformatf("%s_wd%0d", tag, i), obs_wd[i], exp_wd[i]);
    end
    obs_adr.delete(); obs_wd.delete(); exp_adr.delete(); exp_wd.delete();
  endtask

  initial begin
    logic [7:0] wc;
    int n;
    reset = 1'b1; InValid = 1'b0; Start = 1'b0; BaseAdr = 32'd0; MemReady = 1'b0;
    set_fields(4'd0, 2'd0, 6'd0, 4'd0, 4'd0, 24'd0);
    tick(2);
    reset = 1'b0;
    tick(1);
    chk("rst_inready", {31'd0, InReady}, 32'd1);
    chk("rst_memwe", {31'd0, MemWE}, 32'd0);
    chk("rst_memadr", MemAdr, 32'd0);
    chk("rst_memwd", MemWD, 32'd0);
    chk("rst_wordcount", {24'd0, WordCount}, 32'd0);
    chk("rst_err", {31'd0, Err}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);

    // ADD R2,R1,#5
    start(32'h100);
    MemReady = 1'b1;
    we_cycles = 0;
    push(4'hE, 2'd0, 6'b101000, 4'd1, 4'd2, 24'h005);
    drain();
    chk("add_we_cycles", 32'(we_cycles), 32'd1);
    chk("add_wd_const", obs_wd[0], 32'hE281_2005);
    chk("add_adr_const", obs_adr[0], 32'h100);
    chk("add_wordcount", {24'd0, WordCount}, 32'd1);
    compare("add");

    // Branch
    push(4'hE, 2'd2, 6'b100000, 4'd0, 4'd0, 24'hFFFFFE);
    drain();
    chk("b_wd_const", obs_wd[0], 32'hEAFF_FFFE);
    chk("b_wordcount", {24'd0, WordCount}, 32'd2);
    compare("b");

    // Fill the FIFO with the writer stalled, then hold off a fifth word
    start(32'h100);
    chk("restart_wordcount", {24'd0, WordCount}, 32'd0);
    MemReady = 1'b0;
    for (int i = 0; i < 4; i++) push_rand(1'b1);
    chk("full_inready", {31'd0, InReady}, 32'd0);
    chk("full_memwe", {31'd0, MemWE}, 32'd1);
    chk("full_memadr", MemAdr, 32'h100);
    chk("full_memwd", MemWD, exp_wd[0]);
    set_fields(4'($urandom), 2'd1, 6'($urandom), 4'($urandom), 4'($urandom), 24'($urandom));
    InValid = 1'b1;
    tick(3);
    chk("held_inready", {31'd0, InReady}, 32'd0);
    chk("held_wordcount", {24'd0, WordCount}, 32'd0);
    chk("held_memadr", MemAdr, 32'h100);
    MemReady = 1'b1;
    wait_acc();
    InValid = 1'b0;
    model_push();
    drain();
    chk("fill_adr4_const", obs_adr[4], 32'h110);
    chk("fill_wordcount", {24'd0, WordCount}, 32'd5);
    compare("fill");

    // Random field sets with a randomly stalling memory
    start(32'h4000);
    rand_rdy = 1'b1;
    for (int i = 0; i < 24; i++) push_rand(1'b0);
    rand_rdy = 1'b0;
    tick(1);
    MemReady = 1'b1;
    drain();
    n = exp_wd.size();
    chk("rand_wordcount", {24'd0, WordCount}, 32'(n));
    compare("rand");

    // Illegal data-processing opcode
    wc = WordCount;
    push(4'hE, 2'd0, 6'b011110, 4'd1, 4'd2, 24'h010);
`ifdef ENC_CHECK_EN
    chk("illegal_err_hi", {31'd0, Err}, 32'd1);
    tick(1);
    chk("illegal_err_lo", {31'd0, Err}, 32'd0);
`else
    chk("illegal_err_tied", {31'd0, Err}, 32'd0);
`endif
    n = exp_wd.size();
    drain();
    chk("illegal_wordcount", {24'd0, WordCount}, 32'(wc) + 32'(n));
    compare("illegal");

    // Reset while a write is pending
    MemReady = 1'b0;
    for (int i = 0; i < 3; i++) push_rand(1'b1);
    tick(2);
    chk("midwr_memwe_pre", {31'd0, MemWE}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("midwr_memwe", {31'd0, MemWE}, 32'd0);
    chk("midwr_busy", {31'd0, Busy}, 32'd0);
    chk("midwr_inready", {31'd0, InReady}, 32'd1);
    chk("midwr_wordcount", {24'd0, WordCount}, 32'd0);
    chk("midwr_memadr", MemAdr, 32'd0);
    tick(1);
    reset = 1'b0;
    obs_adr.delete(); obs_wd.delete(); exp_adr.delete(); exp_wd.delete();
    tick(1);

    // Base address alignment and 32-bit address wrap
    start(32'h203);
    chk("align_memadr", MemAdr, 32'h200);
    start(32'hFFFF_FFFC);
    chk("wrap_base", MemAdr, 32'hFFFF_FFFC);
    MemReady = 1'b1;
    push_rand(1'b1);
    push_rand(1'b1);
    drain();
    chk("wrap_adr1_const", obs_adr[1], 32'h0);
    compare("wrap");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
